// File: rtl/mips_main_control_if.sv
// Control bus between the MIPS main control FSM (master) and the datapath (slave).
`default_nettype none

interface mips_main_control_if;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mdr_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] ula_op;
    logic       alu_out_write;
    logic [1:0] pc_source;
    logic       epc_write;
    logic       illegal_op;
    logic [4:0] state_dbg;

    modport master (
        input  opcode, zero,
        output pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ula_op,
               alu_out_write, pc_source, epc_write, illegal_op, state_dbg
    );

    modport slave (
        output opcode, zero,
        input  pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write,
               mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, ula_op,
               alu_out_write, pc_source, epc_write, illegal_op, state_dbg
    );
endinterface

`default_nettype wire

// File: rtl/mips_main_control.sv
// Multicycle MIPS main control FSM with registered Moore outputs.
// Optional illegal-opcode exception path: MIPS_CTRL_ILLEGAL_OP_EN.
`default_nettype none

module mips_main_control #(
    parameter int MEM_LATENCY = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mips_main_control_if.master  bus
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [3:0] WAIT_LOAD = 4'(MEM_LATENCY - 1);

    typedef enum logic [4:0] {
        S_RESET       = 5'd0,
        S_FETCH       = 5'd1,
        S_FETCH_WAIT  = 5'd2,
        S_FETCH_LATCH = 5'd3,
        S_DECODE      = 5'd4,
        S_MEM_ADDR    = 5'd5,
        S_MEM_READ    = 5'd6,
        S_MEM_WAIT    = 5'd7,
        S_MEM_WB      = 5'd8,
        S_MEM_WRITE   = 5'd9,
        S_R_EXEC      = 5'd10,
        S_R_WB        = 5'd11,
        S_ADDI_EXEC   = 5'd12,
        S_ADDI_WB     = 5'd13,
        S_BRANCH      = 5'd14,
        S_JUMP        = 5'd15,
        S_EXCEPT      = 5'd16,
        S_NOP_DONE    = 5'd17
    } state_t;

    // br/bne hold the branch qualification so pc_write can follow zero live.
    typedef struct packed {
        logic       pc_write;
        logic       br;
        logic       bne;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mdr_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] ula_op;
        logic       alu_out_write;
        logic [1:0] pc_source;
        logic       epc_write;
        logic       illegal_op;
    } ctrl_t;

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ctrl_t      ctrl_q, ctrl_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_RESET:       state_d = S_FETCH;
            S_FETCH: begin
                state_d = S_FETCH_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            S_FETCH_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_FETCH_LATCH;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_FETCH_LATCH: state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_R:           state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    OP_ADDI:        state_d = S_ADDI_EXEC;
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
                    default:        state_d = S_EXCEPT;
`else
                    default:        state_d = S_NOP_DONE;
`endif
                endcase
            end
            S_MEM_ADDR:    state_d = (bus.opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ: begin
                state_d = S_MEM_WAIT;
                cnt_d   = WAIT_LOAD;
            end
            S_MEM_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_MEM_WB;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_R_EXEC:      state_d = S_R_WB;
            S_ADDI_EXEC:   state_d = S_ADDI_WB;
            S_MEM_WB, S_MEM_WRITE, S_R_WB, S_ADDI_WB,
            S_BRANCH, S_JUMP, S_EXCEPT, S_NOP_DONE:
                           state_d = S_FETCH;
            default:       state_d = S_FETCH;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it.
    always_comb begin
        ctrl_d = '0;
        case (state_d)
            S_FETCH:       ctrl_d.mem_read = 1'b1;
            S_FETCH_WAIT:  ctrl_d.mem_read = 1'b1;
            S_FETCH_LATCH: begin
                ctrl_d.ir_write  = 1'b1;
                ctrl_d.alu_src_b = 2'b01;
                ctrl_d.pc_write  = 1'b1;
            end
            S_DECODE: begin
                ctrl_d.alu_src_b     = 2'b11;
                ctrl_d.alu_out_write = 1'b1;
            end
            S_MEM_ADDR, S_ADDI_EXEC: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.alu_src_b     = 2'b10;
                ctrl_d.alu_out_write = 1'b1;
            end
            S_MEM_READ: begin
                ctrl_d.mem_read = 1'b1;
                ctrl_d.i_or_d   = 1'b1;
            end
            S_MEM_WAIT: begin
                ctrl_d.mem_read  = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
                ctrl_d.mdr_write = (cnt_d == 4'd0);
            end
            S_MEM_WB: begin
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_to_reg = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_d.mem_write = 1'b1;
                ctrl_d.i_or_d    = 1'b1;
            end
            S_R_EXEC: begin
                ctrl_d.alu_src_a     = 1'b1;
                ctrl_d.ula_op        = 2'b10;
                ctrl_d.alu_out_write = 1'b1;
            end
            S_R_WB: begin
                ctrl_d.reg_write = 1'b1;
                ctrl_d.reg_dst   = 1'b1;
            end
            S_ADDI_WB:     ctrl_d.reg_write = 1'b1;
            S_BRANCH: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.ula_op    = 2'b01;
                ctrl_d.pc_source = 2'b01;
                ctrl_d.br        = 1'b1;
                ctrl_d.bne       = (bus.opcode == OP_BNE);
            end
            S_JUMP: begin
                ctrl_d.pc_source = 2'b10;
                ctrl_d.pc_write  = 1'b1;
            end
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
            S_EXCEPT: begin
                ctrl_d.epc_write  = 1'b1;
                ctrl_d.illegal_op = 1'b1;
                ctrl_d.pc_source  = 2'b11;
                ctrl_d.pc_write   = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            cnt_q   <= 4'd0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign bus.pc_write      = ctrl_q.pc_write | (ctrl_q.br & (bus.zero ^ ctrl_q.bne));
    assign bus.i_or_d        = ctrl_q.i_or_d;
    assign bus.mem_read      = ctrl_q.mem_read;
    assign bus.mem_write     = ctrl_q.mem_write;
    assign bus.ir_write      = ctrl_q.ir_write;
    assign bus.mdr_write     = ctrl_q.mdr_write;
    assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
    assign bus.reg_dst       = ctrl_q.reg_dst;
    assign bus.reg_write     = ctrl_q.reg_write;
    assign bus.alu_src_a     = ctrl_q.alu_src_a;
    assign bus.alu_src_b     = ctrl_q.alu_src_b;
    assign bus.ula_op        = ctrl_q.ula_op;
    assign bus.alu_out_write = ctrl_q.alu_out_write;
    assign bus.pc_source     = ctrl_q.pc_source;
    assign bus.state_dbg     = state_q;
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
    assign bus.epc_write     = ctrl_q.epc_write;
    assign bus.illegal_op    = ctrl_q.illegal_op;
`else
    assign bus.epc_write     = 1'b0;
    assign bus.illegal_op    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mips_main_control.sv
// Bench for mips_main_control: per-instruction expected output traces built from the instruction rules.
`default_nettype none

module tb_mips_main_control;

    localparam int L = 3;

    // Output word bit positions, MSB first:
    // pc_write i_or_d mem_read mem_write ir_write mdr_write mem_to_reg reg_dst
    // reg_write alu_src_a alu_src_b[2] ula_op[2] alu_out_write pc_source[2] epc_write illegal_op
    localparam logic [18:0] PCW    = 19'h40000;
    localparam logic [18:0] IOD    = 19'h20000;
    localparam logic [18:0] MR     = 19'h10000;
    localparam logic [18:0] MW     = 19'h08000;
    localparam logic [18:0] IRW    = 19'h04000;
    localparam logic [18:0] MDR    = 19'h02000;
    localparam logic [18:0] M2R    = 19'h01000;
    localparam logic [18:0] RD     = 19'h00800;
    localparam logic [18:0] RW     = 19'h00400;
    localparam logic [18:0] SA     = 19'h00200;
    localparam logic [18:0] SB_4   = 19'h00080;
    localparam logic [18:0] SB_IMM = 19'h00100;
    localparam logic [18:0] SB_SH  = 19'h00180;
    localparam logic [18:0] UO_SUB = 19'h00020;
    localparam logic [18:0] UO_R   = 19'h00040;
    localparam logic [18:0] AOW    = 19'h00010;
    localparam logic [18:0] PS_OUT = 19'h00004;
    localparam logic [18:0] PS_J   = 19'h00008;
    localparam logic [18:0] PS_EXC = 19'h0000C;
    localparam logic [18:0] EPC    = 19'h00002;
    localparam logic [18:0] ILL    = 19'h00001;

    logic clk = 1'b0;
    logic reset_n;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [18:0] obs;
    logic [18:0] exp_q[$];
    logic [5:0]  ops[7];

    mips_main_control_if bus();

    mips_main_control #(.MEM_LATENCY(L)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.master)
    );

    always #5 clk = ~clk;

    assign obs = {bus.pc_write, bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                  bus.mdr_write, bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                  bus.alu_src_b, bus.ula_op, bus.alu_out_write, bus.pc_source,
                  bus.epc_write, bus.illegal_op};

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %05h expected %05h", tag, got, want);
        end
    endtask

    // Expected per-cycle output words for one instruction, fetch included.
    task automatic build(input logic [5:0] op, input logic z);
        exp_q.delete();
        exp_q.push_back(MR);
        for (int i = 0; i < L; i++) exp_q.push_back(MR);
        exp_q.push_back(IRW | SB_4 | PCW);
        exp_q.push_back(SB_SH | AOW);
        case (op)
            6'b100011: begin
                exp_q.push_back(SA | SB_IMM | AOW);
                exp_q.push_back(MR | IOD);
                for (int i = 0; i < L; i++)
                    exp_q.push_back(MR | IOD | ((i == L - 1) ? MDR : 19'h0));
                exp_q.push_back(RW | M2R);
            end
            6'b101011: begin
                exp_q.push_back(SA | SB_IMM | AOW);
                exp_q.push_back(MW | IOD);
            end
            6'b000000: begin
                exp_q.push_back(SA | UO_R | AOW);
                exp_q.push_back(RW | RD);
            end
            6'b001000: begin
                exp_q.push_back(SA | SB_IMM | AOW);
                exp_q.push_back(RW);
            end
            6'b000100: exp_q.push_back(SA | UO_SUB | PS_OUT | (z ? PCW : 19'h0));
            6'b000101: exp_q.push_back(SA | UO_SUB | PS_OUT | (z ? 19'h0 : PCW));
            6'b000010: exp_q.push_back(PS_J | PCW);
`ifdef MIPS_CTRL_ILLEGAL_OP_EN
            default:   exp_q.push_back(EPC | ILL | PS_EXC | PCW);
`else
            default:   exp_q.push_back(19'h0);
`endif
        endcase
    endtask

    // Entered at the negedge of a FETCH cycle; checks up to ncyc cycles (all if negative).
    task automatic run_instr(input logic [5:0] op, input logic z, input string name, input int ncyc);
        int n;
        bus.opcode = op;
        bus.zero   = z;
        build(op, z);
        n = (ncyc < 0) ? exp_q.size() : ncyc;
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s op=%b z=%0d cyc%0d", name, op, z, i + 1), obs, exp_q[i]);
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    initial begin
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011; ops[3] = 6'b000100;
        ops[4] = 6'b000101; ops[5] = 6'b000010; ops[6] = 6'b001000;
        reset_n    = 1'b0;
        bus.opcode = 6'b0;
        bus.zero   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("reset_outputs", obs, 19'h0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        run_instr(6'b000000, 1'b0, "rtype",    -1);
        run_instr(6'b100011, 1'b0, "lw",       -1);
        run_instr(6'b101011, 1'b1, "sw",       -1);
        run_instr(6'b001000, 1'b0, "addi",     -1);
        run_instr(6'b000100, 1'b1, "beq_take", -1);
        run_instr(6'b000101, 1'b1, "bne_not",  -1);
        run_instr(6'b000100, 1'b0, "beq_not",  -1);
        run_instr(6'b000101, 1'b0, "bne_take", -1);
        run_instr(6'b000010, 1'b0, "jump",     -1);
        run_instr(6'b111111, 1'b0, "illegal",  -1);
        run_instr(6'b000000, 1'b1, "after_ill", -1);

        repeat (40) begin
            logic [5:0] op;
            int k;
            k  = int'($urandom_range(0, 7));
            op = (k == 7) ? 6'($urandom) : ops[k];
            run_instr(op, 1'($urandom_range(0, 1)), "rand", -1);
        end

        // Abort a load in its second memory-wait cycle.
        run_instr(6'b100011, 1'b0, "lw_abort", L + 6);
        reset_n = 1'b0;
        #1;
        check("async_reset", obs, 19'h0);
        repeat (2) begin
            @(negedge clk);
            check("held_reset", obs, 19'h0);
        end
        reset_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        run_instr(6'b000000, 1'b0, "post_reset", -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
